// File: rtl/me_pkg.sv
// Shared widths, memory opcodes, pipeline record types and store/alignment helpers
// for the memory-access stage.
package me_pkg;

  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int INSTR_W    = 32;
  localparam int REG_IDX_W  = 5;
  localparam int DEST_SRC_W = 2;
  localparam int MEM_OP_W   = 4;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NONE = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LB   = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LH   = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LW   = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LBU  = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LHU  = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SB   = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SH   = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SW   = 4'd8;

  // Everything handed to wb in one registered record.
  typedef struct packed {
    logic [ADDR_W-1:0]     pc;
    logic [INSTR_W-1:0]    instr;
    logic [DEST_SRC_W-1:0] dest_src;
    logic [REG_IDX_W-1:0]  dest_reg;
    logic [WORD_W-1:0]     alu_eval;
    logic [WORD_W-1:0]     mem_data;
    logic                  misalign;
  } out_t;

  typedef struct packed {
    logic [ADDR_W-1:0]     pc;
    logic [INSTR_W-1:0]    instr;
    logic [MEM_OP_W-1:0]   mem_op;
    logic [DEST_SRC_W-1:0] dest_src;
    logic [REG_IDX_W-1:0]  dest_reg;
    logic [WORD_W-1:0]     alu_eval;
  } cap_t;

  function automatic logic is_mem_op(input logic [MEM_OP_W-1:0] op);
    return (op != MEM_OP_NONE) && (op <= MEM_OP_SW);
  endfunction

  function automatic logic is_store(input logic [MEM_OP_W-1:0] op);
    return (op == MEM_OP_SB) || (op == MEM_OP_SH) || (op == MEM_OP_SW);
  endfunction

  function automatic logic is_misaligned(input logic [MEM_OP_W-1:0] op,
                                         input logic [1:0]          lo);
    logic half_op;
    logic word_op;
    half_op = (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
    word_op = (op == MEM_OP_LW) || (op == MEM_OP_SW);
    return (half_op && lo[0]) || (word_op && (lo != 2'b00));
  endfunction

  function automatic logic [WORD_W-1:0] store_wdata(input logic [MEM_OP_W-1:0] op,
                                                    input logic [WORD_W-1:0]   d);
    case (op)
      MEM_OP_SB: return {4{d[7:0]}};
      MEM_OP_SH: return {2{d[15:0]}};
      default:   return d;
    endcase
  endfunction

  function automatic logic [3:0] store_wstrb(input logic [MEM_OP_W-1:0] op,
                                             input logic [1:0]          lo);
    case (op)
      MEM_OP_SB: return 4'b0001 << lo;
      MEM_OP_SH: return 4'b0011 << {lo[1], 1'b0};
      MEM_OP_SW: return 4'hf;
      default:   return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/me_load_align.sv
// Combinational load-data alignment: picks the byte/half addressed by addr_lo
// out of the fetched word and sign- or zero-extends it.
module me_load_align
  import me_pkg::*;
(
  input  logic [MEM_OP_W-1:0] mem_op,
  input  logic [1:0]          addr_lo,
  input  logic [WORD_W-1:0]   rdata,
  output logic [WORD_W-1:0]   data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (mem_op)
      MEM_OP_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_LBU: data = {24'h0, byte_sel};
      MEM_OP_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_OP_LHU: data = {16'h0, half_sel};
      MEM_OP_LW:  data = rdata;
      default:    data = '0;
    endcase
  end

endmodule

// File: rtl/me.sv
// Memory-access pipeline stage: issues data-memory loads/stores over req/ack,
// aligns load data and registers the instruction record for wb.
module me
  import me_pkg::*;
(
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  stall,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [INSTR_W-1:0]    i_instr,
  input  logic [MEM_OP_W-1:0]   i_mem_op,
  input  logic [DEST_SRC_W-1:0] i_dest_src,
  input  logic [REG_IDX_W-1:0]  i_dest_reg,
  input  logic [WORD_W-1:0]     i_alu_eval,
  input  logic [WORD_W-1:0]     i_store_data,
  output logic                  o_busy,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_W-1:0]     o_dmem_addr,
  output logic [WORD_W-1:0]     o_dmem_wdata,
  output logic [3:0]            o_dmem_wstrb,
  input  logic [WORD_W-1:0]     i_dmem_rdata,
  input  logic                  i_dmem_ack,
  output logic [ADDR_W-1:0]     o_pc,
  output logic [INSTR_W-1:0]    o_instr,
  output logic [DEST_SRC_W-1:0] o_dest_src,
  output logic [REG_IDX_W-1:0]  o_dest_reg,
  output logic [WORD_W-1:0]     o_alu_eval,
  output logic [WORD_W-1:0]     o_mem_data,
  output logic                  o_misalign
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HELD = 2'd2
  } state_e;

  state_e              state_q, state_d;
  out_t                out_q, out_d;
  out_t                held_q, held_d;
  cap_t                cap_q, cap_d;
  logic                busy_q, busy_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;

  logic [WORD_W-1:0]   load_data;
  logic                in_misalign;
  out_t                result;

  me_load_align u_load_align (
    .mem_op  (cap_q.mem_op),
    .addr_lo (cap_q.alu_eval[1:0]),
    .rdata   (i_dmem_rdata),
    .data    (load_data)
  );

  // Record produced when the captured transaction completes.
  always_comb begin
    result          = '0;
    result.pc       = cap_q.pc;
    result.instr    = cap_q.instr;
    result.dest_src = cap_q.dest_src;
    result.dest_reg = is_store(cap_q.mem_op) ? '0 : cap_q.dest_reg;
    result.alu_eval = cap_q.alu_eval;
    result.mem_data = is_store(cap_q.mem_op) ? '0 : load_data;
    result.misalign = 1'b0;
  end

  assign in_misalign = is_misaligned(i_mem_op, i_alu_eval[1:0]);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    held_d  = held_q;
    cap_d   = cap_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (!stall) begin
          if (is_mem_op(i_mem_op) && !in_misalign) begin
            state_d        = ST_WAIT;
            cap_d.pc       = i_pc;
            cap_d.instr    = i_instr;
            cap_d.mem_op   = i_mem_op;
            cap_d.dest_src = i_dest_src;
            cap_d.dest_reg = i_dest_reg;
            cap_d.alu_eval = i_alu_eval;
            req_d          = 1'b1;
            we_d           = is_store(i_mem_op);
            addr_d         = {i_alu_eval[ADDR_W-1:2], 2'b00};
            wdata_d        = store_wdata(i_mem_op, i_store_data);
            wstrb_d        = store_wstrb(i_mem_op, i_alu_eval[1:0]);
            out_d          = '0;
          end else begin
            out_d.pc       = i_pc;
            out_d.instr    = i_instr;
            out_d.dest_src = i_dest_src;
            out_d.dest_reg = in_misalign ? '0 : i_dest_reg;
            out_d.alu_eval = i_alu_eval;
            out_d.mem_data = '0;
            out_d.misalign = in_misalign;
          end
        end
      end
      ST_WAIT: begin
        if (i_dmem_ack) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          wstrb_d = '0;
          if (stall) begin
            state_d = ST_HELD;
            held_d  = result;
          end else begin
            state_d = ST_IDLE;
            out_d   = result;
          end
        end
      end
      ST_HELD: begin
        if (!stall) begin
          state_d = ST_IDLE;
          out_d   = held_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      held_q  <= '0;
      cap_q   <= '0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      held_q  <= held_d;
      cap_q   <= cap_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
    end
  end

  assign o_busy       = busy_q;
  assign o_dmem_req   = req_q;
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_wstrb = wstrb_q;
  assign o_pc         = out_q.pc;
  assign o_instr      = out_q.instr;
  assign o_dest_src   = out_q.dest_src;
  assign o_dest_reg   = out_q.dest_reg;
  assign o_alu_eval   = out_q.alu_eval;
  assign o_mem_data   = out_q.mem_data;
  assign o_misalign   = out_q.misalign;

endmodule
